// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: drains the read port into a 2-entry
// buffer and presents the words on a valid/ready stream, counting delivered words.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow,
  input  logic                  clr_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic [FIFO_WIDTH-1:0] buf_d [2];
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic       pop;
  logic       capture;
  logic [1:0] pending;
  logic [1:0] tail;

  assign pop     = (occ_q != 2'd0) && m_ready;
  // A word returning together with an underflow or a flush is dropped.
  assign capture = infl_q && !flush && !fifo_underflow;
  // Occupancy after this edge, counting the word already in flight.
  assign pending = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign tail    = occ_q - {1'b0, pop};

  assign fifo_rd_en = !rst && (state_q == RUN) && enable && !fifo_empty &&
                      !flush && (pending < 2'd2);

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf_q[0];
  assign rd_count      = cnt_q;
  assign err_underflow = err_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((occ_q == 2'd0) && !infl_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = enable ? RUN : IDLE;
    end
  end

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        buf_d[0] = buf_q[1];
      end
      if (capture) begin
        buf_d[tail[0]] = fifo_dout;
      end
      occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(pop);
    err_d = err_q;
    if (fifo_underflow) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      infl_q  <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      infl_q  <= fifo_rd_en;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port and a
// stream monitor recording every delivered beat.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst, enable, flush, m_ready, clr_err;
  logic        fifo_empty, fifo_underflow, fifo_rd_en;
  logic [15:0] fifo_dout = 16'h0;
  logic        m_valid, err_underflow, busy;
  logic [15:0] m_data, rd_count;

  logic        force_empty, force_uf;
  logic [15:0] fmem [0:255];
  int unsigned wp = 0;
  int unsigned rp = 0;

  logic [15:0] beats [$];
  int          rd_pulses = 0;
  int          bad_rd = 0;
  int          tests = 0;
  int          fails = 0;
  int          base, p0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_count(rd_count), .err_underflow(err_underflow), .clr_err(clr_err), .busy(busy)
  );

  assign fifo_empty     = force_empty || (wp == rp);
  assign fifo_underflow = force_uf;

  // FIFO read port: data appears one cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && (wp != rp)) begin
      fifo_dout <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) beats.push_back(m_data);
    if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    fmem[wp[7:0]] = d;
    wp = wp + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) $display("[TB] %s = %0h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beats(input string tag, input int b, input int n, input int first);
    chk({tag, "_count"}, 32'(beats.size() - b), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (b + k < beats.size())
        chk($sformatf("%s_beat%0d", tag, k), 32'(beats[b + k]), 32'(first + k));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
    force_empty = 1'b0; force_uf = 1'b0;
    cyc(3);
    chk("init_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("init_valid", 32'(m_valid), 32'd0);
    chk("init_count", 32'(rd_count), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Streaming: one read and one beat per cycle, valid two samples after first read.
    for (int v = 1; v <= 8; v++) push(16'(v));
    base = beats.size(); p0 = rd_pulses;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      cyc();
      chk($sformatf("st_rd_en%0d", i), 32'(fifo_rd_en), 32'(i < 8));
      chk($sformatf("st_valid%0d", i), 32'(m_valid), 32'(i >= 2 && i <= 9));
      if (i >= 2 && i <= 9) chk($sformatf("st_data%0d", i), 32'(m_data), 32'(i - 1));
    end
    chk("st_count", 32'(rd_count), 32'd8);
    chk("st_pulses", 32'(rd_pulses - p0), 32'd8);
    chk("st_err", 32'(err_underflow), 32'd0);
    chk_beats("st", base, 8, 1);
    enable = 1'b0;
    cyc(3);
    chk("st_idle", 32'(busy), 32'd0);

    // Reset mid-stream drops the buffered word and the one in flight.
    push(16'h11); push(16'h12); push(16'h13); push(16'h14);
    enable = 1'b1; m_ready = 1'b1;
    cyc(3);
    chk("rs_pre_data", 32'(m_data), 32'h11);
    rst = 1'b1; enable = 1'b0;
    #1 chk("rs_rd_gate", 32'(fifo_rd_en), 32'd0);
    cyc();
    chk("rs_valid", 32'(m_valid), 32'd0);
    chk("rs_data", 32'(m_data), 32'd0);
    chk("rs_count", 32'(rd_count), 32'd0);
    chk("rs_err", 32'(err_underflow), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    cyc();
    rst = 1'b0;
    base = beats.size();
    cyc(2);
    chk("rs_post_valid", 32'(m_valid), 32'd0);
    enable = 1'b1;
    cyc(8);
    chk_beats("rs", base, 2, 16'h13);
    chk("rs_count2", 32'(rd_count), 32'd2);
    enable = 1'b0;
    cyc(3);

    // Backpressure: two reads fill the buffer, head held until the sink is ready.
    for (int v = 1; v <= 8; v++) push(16'(v));
    base = beats.size(); p0 = rd_pulses;
    m_ready = 1'b0; enable = 1'b1;
    cyc(10);
    chk("bp_pulses", 32'(rd_pulses - p0), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'h1);
    m_ready = 1'b1;
    cyc(12);
    chk_beats("bp", base, 8, 1);
    chk("bp_count", 32'(rd_count), 32'd10);
    chk("bp_pulses2", 32'(rd_pulses - p0), 32'd8);
    enable = 1'b0;
    cyc(3);

    // Empty FIFO: no reads; sticky underflow flag with set-over-clear priority.
    force_empty = 1'b1; enable = 1'b1; p0 = rd_pulses;
    cyc(20);
    chk("em_pulses", 32'(rd_pulses - p0), 32'd0);
    chk("em_valid", 32'(m_valid), 32'd0);
    force_uf = 1'b1;
    cyc();
    force_uf = 1'b0;
    chk("uf_set", 32'(err_underflow), 32'd1);
    cyc(3);
    chk("uf_sticky", 32'(err_underflow), 32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("uf_clr", 32'(err_underflow), 32'd0);
    clr_err = 1'b1; force_uf = 1'b1;
    cyc();
    clr_err = 1'b0; force_uf = 1'b0;
    chk("uf_set_wins", 32'(err_underflow), 32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("uf_clr2", 32'(err_underflow), 32'd0);
    enable = 1'b0; force_empty = 1'b0;
    cyc(3);

    // Underflow coinciding with a returning word discards that word.
    push(16'h31);
    base = beats.size();
    enable = 1'b1; m_ready = 1'b1;
    cyc();
    chk("ud_rd_en", 32'(fifo_rd_en), 32'd1);
    cyc();
    force_uf = 1'b1;
    cyc();
    force_uf = 1'b0;
    chk("ud_valid", 32'(m_valid), 32'd0);
    chk("ud_err", 32'(err_underflow), 32'd1);
    enable = 1'b0; clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    cyc(2);
    chk("ud_beats", 32'(beats.size() - base), 32'd0);

    // Enable drop with occ=1 and a word in flight: both words still delivered.
    push(16'h21); push(16'h22); push(16'h23); push(16'h24);
    base = beats.size(); p0 = rd_pulses;
    enable = 1'b1; m_ready = 1'b1;
    cyc(3);
    chk("ed_data", 32'(m_data), 32'h21);
    chk("ed_rd_before", 32'(fifo_rd_en), 32'd1);
    enable = 1'b0;
    #1 chk("ed_rd_after", 32'(fifo_rd_en), 32'd0);
    cyc();
    chk("ed_data2", 32'(m_data), 32'h22);
    chk("ed_busy1", 32'(busy), 32'd1);
    cyc();
    chk("ed_valid0", 32'(m_valid), 32'd0);
    chk("ed_busy2", 32'(busy), 32'd1);
    cyc();
    chk("ed_busy3", 32'(busy), 32'd0);
    chk_beats("ed", base, 2, 16'h21);
    chk("ed_pulses", 32'(rd_pulses - p0), 32'd2);
    chk("ed_count", 32'(rd_count), 32'd12);

    // Flush with a buffered word and one in flight; resume with the next FIFO word.
    push(16'h25); push(16'h26); push(16'h27); push(16'h28);
    base = beats.size(); p0 = rd_pulses;
    enable = 1'b1; m_ready = 1'b0;
    cyc(3);
    chk("fl_pre_data", 32'(m_data), 32'h23);
    flush = 1'b1;
    #1 chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
    cyc();
    flush = 1'b0; m_ready = 1'b1;
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_count", 32'(rd_count), 32'd12);
    chk("fl_busy", 32'(busy), 32'd1);
    cyc(10);
    chk_beats("fl", base, 4, 16'h25);
    chk("fl_count2", 32'(rd_count), 32'd16);
    chk("fl_pulses", 32'(rd_pulses - p0), 32'd6);
    enable = 1'b0;
    cyc(3);
    chk("end_busy", 32'(busy), 32'd0);
    chk("no_rd_on_empty", 32'(bad_rd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
